byte_mix_columns_unit: RTL and testbench
========================================

// Module: byte_mix_columns_unit
// PURPOSE
//  Byte-serial AES MixColumns stage placed directly downstream of the byte permutation (ShiftRows) unit.
//  Accepts the permuted state one byte per cycle in column-major order (byte i = row i%4, column i/4).
//  Buffers each 4-byte column, applies the GF(2^8) MixColumns matrix and streams mixed bytes out in the same order.
//  Bypass mode passes bytes through unmixed with identical latency, for the final AES round.
// PARAMETERS
//  BYPASS_EN  1  1: bypass input honoured; 0: bypass ignored (always mix)
// PORTS
//  clk          in   1  single clock; all state updates on rising edge
//  rst          in   1  asynchronous, active-low reset
//  rst_synch    in   1  synchronous clear, active-high; same effect as rst on next edge
//  in_valid     in   1  in_byte is valid this cycle (no backpressure; stage always accepts)
//  in_byte      in   8  permuted state byte
//  bypass       in   1  sampled with byte 0 of each column; 1 = output the column unmixed
//  out_valid    out  1  out_byte is valid
//  out_byte     out  8  mixed (or bypassed) state byte, column-major order
//  out_last     out  1  high with out_valid on state byte 15
// BEHAVIOUR
//  - Reset (rst low, or rst_synch high at an edge): out_valid=0, out_byte=8'h00, out_last=0.
//    All counters, buffers and bypass flag are cleared; a partially received column is discarded.
//  - Input side: 2-bit in_cnt indexes the column byte; 4-bit in_idx indexes the state byte (wraps 15->0).
//    When in_valid=1, in_byte is written to col_buf[in_cnt] and in_cnt/in_idx increment.
//    in_valid=0 holds all input-side state (gaps allowed anywhere, including mid-column).
//  - Column complete (accept with in_cnt==3): on that edge, mix(col_buf[0..2], in_byte) -> out_sr[0..3].
//    Also out_cnt=0, drain active=1, and the column's state index base is latched for out_last.
//  - Mix, with a0..a3 = rows 0..3:
//      b0 = 2a0^3a1^a2^a3   b1 = a0^2a1^3a2^a3
//      b2 = a0^a1^2a2^3a3   b3 = 3a0^a1^a2^2a3
//    Definitions: 2x = xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00); 3x = xtime(x)^x; all widths 8 bits.
//  - Bypass: if the column's latched bypass=1 and BYPASS_EN=1, out_sr gets a0..a3 unchanged.
//  - Drain: while drain active, out_valid=1, out_byte=out_sr[out_cnt], and out_cnt increments every cycle.
//    After out_cnt==3 is emitted, drain goes inactive.
//  - out_last=1 exactly when the emitted byte is state byte 15.
//  - Latency: column byte j accepted at cycle t0+j (no gaps) -> output byte j valid at cycle t0+4+j.
//    Back-to-back states at 1 byte/cycle give a gap-free 1 byte/cycle output.
//  - Overlap: the next column fills col_buf while out_sr drains. A column needs >=4 cycles to fill and drain
//    takes exactly 4, so out_sr is never overwritten before it is emptied. No overflow condition exists.
//  - Simultaneous column-complete and final drain byte: the last byte is emitted, out_sr reloads on the same
//    edge, and drain continues with no bubble.
//  - Reset mid-drain: outputs drop to 0 in the same cycle (async) or at the next edge (rst_synch).
//    Unemitted bytes are lost.
// STRUCTURE
//  - Shared package aes_pkg:
//      function xtime(byte); constant AES_POLY=8'h1B; constant STATE_BYTES=16; constant COL_BYTES=4;
//      typedef logic [7:0] aes_byte_t; typedef aes_byte_t aes_col_t [4];
//  - One sub-module: aes_mix_column (combinational aes_col_t -> aes_col_t, implements the matrix above).
//  - Top level holds col_buf, in_cnt/in_idx, bypass flag, out_sr, out_cnt, drain flag and the out_last logic.
// TESTING
//  1 FIPS-197 column: in db,13,53,45 bypass=0 -> out 8e,4d,a1,bc, first output 4 cycles after db.
//  2 Column f2,0a,22,5c -> 9f,dc,58,9d; column d4,bf,5d,30 -> 04,66,81,e5; c6 x4 -> c6 x4; 01 x4 -> 01 x4.
//  3 Two full 16-byte states back-to-back, no gaps -> 32 contiguous out_valid cycles;
//    out_last high only on output bytes 15 and 31.
//  4 bypass=1 on column 2 only -> column 2 bytes appear unchanged, other columns mixed, same timing.
//    With BYPASS_EN=0 the same stimulus gives all columns mixed.
//  5 Random in_valid gaps inside columns -> outputs identical to the no-gap run; each column drains in 4 cycles.
//  6 rst low (and separately rst_synch high) after 2 bytes of a column and mid-drain -> out_valid=0 at once.
//    The next 4 bytes after release form a fresh column 0 with correct output.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, constants and the GF(2^8) doubling helper.
package aes_pkg;

  typedef logic [7:0] aes_byte_t;
  typedef aes_byte_t aes_col_t [4];

  localparam aes_byte_t AES_POLY    = 8'h1B;
  localparam int        STATE_BYTES = 16;
  localparam int        COL_BYTES   = 4;

  // Multiply by x in GF(2^8), reducing by the AES polynomial.
  function automatic aes_byte_t xtime(input aes_byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_mix_column.sv
// Combinational MixColumns for one 4-byte column (a0..a3 = rows 0..3).
module aes_mix_column
  import aes_pkg::*;
(
  input  aes_col_t a,
  output aes_col_t b
);

  aes_byte_t a2 [4];
  aes_byte_t a3 [4];

  // Form 2a and 3a per row, then apply the fixed circulant matrix.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a2[i] = xtime(a[i]);
      a3[i] = a2[i] ^ a[i];
    end
    b[0] = a2[0] ^ a3[1] ^ a[2]  ^ a[3];
    b[1] = a[0]  ^ a2[1] ^ a3[2] ^ a[3];
    b[2] = a[0]  ^ a[1]  ^ a2[2] ^ a3[3];
    b[3] = a3[0] ^ a[1]  ^ a[2]  ^ a2[3];
  end

endmodule

// File: rtl/byte_mix_columns_unit.sv
// Byte-serial MixColumns stage: buffers a column, mixes it, drains it byte by byte.
module byte_mix_columns_unit
  import aes_pkg::*;
#(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rst_synch,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  input  logic       bypass,
  output logic       out_valid,
  output logic [7:0] out_byte,
  output logic       out_last
);

  localparam int IDX_W    = $clog2(STATE_BYTES);
  localparam int LAST_COL = (STATE_BYTES / COL_BYTES) - 1;

  // Only rows 0..2 are stored; row 3 arrives on the completing edge.
  aes_byte_t        col_buf_q [3];
  aes_byte_t        col_buf_d [3];
  logic [1:0]       in_cnt_q, in_cnt_d;
  logic [IDX_W-1:0] in_idx_q, in_idx_d;
  logic             byp_q, byp_d;
  aes_col_t         out_sr_q, out_sr_d;
  logic [1:0]       out_cnt_q, out_cnt_d;
  logic             drain_q, drain_d;
  logic [1:0]       col_base_q, col_base_d;

  aes_col_t mix_in;
  aes_col_t mix_out;
  logic     col_done;

  // Column presented to the mixer: three buffered rows plus the live byte.
  always_comb begin
    mix_in[0] = col_buf_q[0];
    mix_in[1] = col_buf_q[1];
    mix_in[2] = col_buf_q[2];
    mix_in[3] = in_byte;
  end

  aes_mix_column u_mix (
    .a (mix_in),
    .b (mix_out)
  );

  assign col_done = in_valid && (in_cnt_q == 2'd3);

  // Next-state: input capture, column load into the drain register, drain stepping.
  always_comb begin
    col_buf_d  = col_buf_q;
    in_cnt_d   = in_cnt_q;
    in_idx_d   = in_idx_q;
    byp_d      = byp_q;
    out_sr_d   = out_sr_q;
    out_cnt_d  = out_cnt_q;
    drain_d    = drain_q;
    col_base_d = col_base_q;

    if (in_valid) begin
      for (int i = 0; i < 3; i++) begin
        if (in_cnt_q == 2'(i)) col_buf_d[i] = in_byte;
      end
      if (in_cnt_q == 2'd0) byp_d = bypass;
      in_cnt_d = in_cnt_q + 2'd1;
      in_idx_d = in_idx_q + 1'b1;
    end

    if (drain_q) begin
      out_cnt_d = out_cnt_q + 2'd1;
      if (out_cnt_q == 2'd3) drain_d = 1'b0;
    end

    // A completing column wins over the final drain step, so no bubble appears.
    if (col_done) begin
      out_sr_d   = (byp_q && BYPASS_EN) ? mix_in : mix_out;
      out_cnt_d  = 2'd0;
      drain_d    = 1'b1;
      col_base_d = in_idx_q[IDX_W-1:2];
    end

    if (rst_synch) begin
      for (int i = 0; i < 3; i++) col_buf_d[i] = '0;
      for (int i = 0; i < 4; i++) out_sr_d[i] = '0;
      in_cnt_d   = '0;
      in_idx_d   = '0;
      byp_d      = 1'b0;
      out_cnt_d  = '0;
      drain_d    = 1'b0;
      col_base_d = '0;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) col_buf_q[i] <= '0;
      for (int i = 0; i < 4; i++) out_sr_q[i] <= '0;
      in_cnt_q   <= '0;
      in_idx_q   <= '0;
      byp_q      <= 1'b0;
      out_cnt_q  <= '0;
      drain_q    <= 1'b0;
      col_base_q <= '0;
    end else begin
      col_buf_q  <= col_buf_d;
      in_cnt_q   <= in_cnt_d;
      in_idx_q   <= in_idx_d;
      byp_q      <= byp_d;
      out_sr_q   <= out_sr_d;
      out_cnt_q  <= out_cnt_d;
      drain_q    <= drain_d;
      col_base_q <= col_base_d;
    end
  end

  assign out_valid = drain_q;
  assign out_byte  = drain_q ? out_sr_q[out_cnt_q] : 8'h00;
  assign out_last  = drain_q && (col_base_q == 2'(LAST_COL)) && (out_cnt_q == 2'd3);

endmodule

// File: tb/tb_byte_mix_columns_unit.sv
// Randomized bench for byte_mix_columns_unit against a GF(2^8) matrix model.
module tb_byte_mix_columns_unit;

  logic       clk = 1'b0;
  logic       rst, rst_synch, in_valid, bypass;
  logic [7:0] in_byte;
  logic       out_valid, out_last, nb_valid, nb_last;
  logic [7:0] out_byte, nb_byte;

  byte_mix_columns_unit #(.BYPASS_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .rst_synch(rst_synch), .in_valid(in_valid), .in_byte(in_byte),
    .bypass(bypass), .out_valid(out_valid), .out_byte(out_byte), .out_last(out_last)
  );

  byte_mix_columns_unit #(.BYPASS_EN(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .rst_synch(rst_synch), .in_valid(in_valid), .in_byte(in_byte),
    .bypass(bypass), .out_valid(nb_valid), .out_byte(nb_byte), .out_last(nb_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] b;
    logic       last;
    int         cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int mm [4][4] = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};

  logic [7:0] m_col [4];
  int         m_cnt = 0;
  int         m_idx = 0;
  logic       m_byp = 1'b0;

  // Schoolbook polynomial product followed by reduction mod x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input int k);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++)
      if (((k >> i) & 1) != 0) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h11B << (i - 8));
    return p[7:0];
  endfunction

  task automatic model_accept(input logic [7:0] b, input logic byp);
    exp_t e;
    logic [7:0] mixed;
    int base;
    if (m_cnt == 0) m_byp = byp;
    m_col[m_cnt] = b;
    m_cnt++;
    m_idx = (m_idx + 1) % 16;
    if (m_cnt == 4) begin
      base = (m_idx + 12) % 16;
      for (int r = 0; r < 4; r++) begin
        mixed = 8'h00;
        for (int c = 0; c < 4; c++) mixed = mixed ^ gf_mul(m_col[c], mm[r][c]);
        e.last = ((base + r) == 15);
        e.cyc  = cyc + 1 + r;
        e.b    = m_byp ? m_col[r] : mixed;
        q0.push_back(e);
        e.b    = mixed;
        q1.push_back(e);
      end
      m_cnt = 0;
    end
  endtask

  task automatic model_clear();
    m_cnt = 0;
    m_idx = 0;
    q0.delete();
    q1.delete();
  endtask

  // ---------------- monitor ----------------
  bit         mon_en = 1'b0;
  logic [7:0] got_q[$];
  int         run = 0;
  int         max_run = 0;
  int         last_cnt = 0;

  task automatic mon(input int p, input logic v, input logic [7:0] b, input logic l);
    exp_t  e;
    bit    have;
    string pre;
    pre  = (p != 0) ? "nb_" : "";
    have = (p != 0) ? (q1.size() > 0) : (q0.size() > 0);
    if (v) begin
      if (!have) check({pre, "spurious_valid"}, 32'(v), 32'd0);
      else begin
        e = (p != 0) ? q1.pop_front() : q0.pop_front();
        check({pre, "out_byte"}, 32'(b), 32'(e.b));
        check({pre, "out_last"}, 32'(l), 32'(e.last));
        check({pre, "out_cycle"}, cyc, e.cyc);
      end
    end else if (have) begin
      e = (p != 0) ? q1[0] : q0[0];
      if (e.cyc <= cyc) begin
        check({pre, "out_valid"}, 32'(v), 32'd1);
        if (p != 0) void'(q1.pop_front()); else void'(q0.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, out_valid, out_byte, out_last);
      mon(1, nb_valid, nb_byte, nb_last);
      if (out_valid) begin
        got_q.push_back(out_byte);
        run++;
        if (out_last) last_cnt++;
      end else run = 0;
      if (run > max_run) max_run = run;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [7:0] b, input logic byp);
    in_valid = 1'b1;
    in_byte  = b;
    bypass   = byp;
    model_accept(b, byp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    bypass   = 1'($urandom);
    in_byte  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic sync_reset();
    rst_synch = 1'b1;
    @(posedge clk); #1;
    rst_synch = 1'b0;
    model_clear();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_byte"}, 32'(out_byte), 32'd0);
    check({tag, "_last"}, 32'(out_last), 32'd0);
    check({tag, "_nb_valid"}, 32'(nb_valid), 32'd0);
  endtask

  logic [7:0] vec_in  [16] = '{8'hdb, 8'h13, 8'h53, 8'h45, 8'hf2, 8'h0a, 8'h22, 8'h5c,
                               8'hd4, 8'hbf, 8'h5d, 8'h30, 8'hc6, 8'hc6, 8'hc6, 8'hc6};
  logic [7:0] vec_out [16] = '{8'h8e, 8'h4d, 8'ha1, 8'hbc, 8'h9f, 8'hdc, 8'h58, 8'h9d,
                               8'h04, 8'h66, 8'h81, 8'he5, 8'hc6, 8'hc6, 8'hc6, 8'hc6};
  logic [7:0] data  [16];
  logic [7:0] run_a [16];
  logic [7:0] byp_in[16];

  initial begin
    rst = 1'b0; rst_synch = 1'b0; in_valid = 1'b0; bypass = 1'b0; in_byte = 8'h00;
    idle(2);
    check_quiet("reset");
    rst = 1'b1;
    mon_en = 1'b1;
    idle(1);

    // 1: FIPS-197 column, latency checked by the scoreboard's cycle stamps
    got_q.delete();
    for (int i = 0; i < 4; i++) drive(vec_in[i], 1'b0);
    idle(6);
    check("fips_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("fips_b%0d", i), 32'(got_q[i]), 32'(vec_out[i]));
    $display("txn fips column done, outputs=%0d", got_q.size());

    // 2: further known columns plus all-01 column
    got_q.delete();
    for (int i = 4; i < 16; i++) drive(vec_in[i], 1'b0);
    for (int i = 0; i < 4; i++) drive(8'h01, 1'b0);
    idle(6);
    check("known_count", got_q.size(), 16);
    for (int i = 0; i < 12; i++) check($sformatf("known_b%0d", i), 32'(got_q[i]), 32'(vec_out[i + 4]));
    for (int i = 12; i < 16; i++) check($sformatf("ones_b%0d", i), 32'(got_q[i]), 32'h01);
    $display("txn known columns done, outputs=%0d", got_q.size());

    // 3: two back-to-back states from a fresh start
    sync_reset();
    idle(1);
    max_run = 0; last_cnt = 0;
    for (int i = 0; i < 32; i++) drive(8'($urandom), 1'b0);
    idle(6);
    check("b2b_run", max_run, 32);
    check("b2b_lasts", last_cnt, 2);
    $display("txn back-to-back states: run=%0d lasts=%0d", max_run, last_cnt);

    // 4: bypass requested on column 2 only (non-first bytes carry random bypass)
    got_q.delete();
    for (int i = 0; i < 16; i++) begin
      byp_in[i] = 8'($urandom);
      drive(byp_in[i], (i % 4 == 0) ? (i == 8) : 1'($urandom));
    end
    idle(6);
    for (int i = 8; i < 12; i++) check($sformatf("byp_b%0d", i), 32'(got_q[i]), 32'(byp_in[i]));
    $display("txn bypass column 2 done, outputs=%0d", got_q.size());

    // 5: same state with and without random input gaps
    for (int i = 0; i < 16; i++) data[i] = 8'($urandom);
    got_q.delete();
    for (int i = 0; i < 16; i++) drive(data[i], 1'b0);
    idle(6);
    for (int i = 0; i < 16; i++) run_a[i] = got_q[i];
    got_q.delete();
    for (int i = 0; i < 16; i++) begin
      drive(data[i], 1'b0);
      idle($urandom_range(0, 2));
    end
    idle(6);
    for (int i = 0; i < 16; i++) check($sformatf("gap_b%0d", i), 32'(got_q[i]), 32'(run_a[i]));
    $display("txn gapped state matches gap-free state");

    // 6a: asynchronous reset after 2 bytes of a column, mid-drain
    for (int i = 0; i < 6; i++) drive(8'($urandom), 1'b0);
    #1;
    check("pre_async_valid", 32'(out_valid), 32'd1);
    rst = 1'b0;
    model_clear();
    #1;
    check_quiet("async");
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) drive(8'($urandom), 1'b0);
    idle(6);
    $display("txn async reset mid-drain recovered");

    // 6b: synchronous clear in the same situation
    for (int i = 0; i < 6; i++) drive(8'($urandom), 1'b0);
    sync_reset();
    check_quiet("synch");
    for (int i = 0; i < 4; i++) drive(8'($urandom), 1'b0);
    idle(6);
    $display("txn synchronous clear mid-drain recovered");

    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
